// File: rtl/encoder_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | encoder_sampler: timed snapshot of quadrature counts -> saturated velocity |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module encoder_sampler #(
  parameter int NCH     = 4,
  parameter int PERIOD  = 50000,
  parameter int SHIFT   = 7,
  parameter int VW      = 16,
  parameter int CLR_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                clr_req,
  input  logic [NCH*32-1:0]   cnt_in,
  output logic [NCH-1:0]      cnt_start,
  output logic [NCH-1:0]      cnt_clr_n,
  output logic [NCH*VW-1:0]   vel_out,
  output logic                vel_valid,
  input  logic                vel_ack,
  output logic                overrun,
  output logic                tick,
  output logic                busy
);

  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic signed [31:0] VMAX = (32'sd1 <<< (VW - 1)) - 32'sd1;
  localparam logic signed [31:0] VMIN = -(32'sd1 <<< (VW - 1));

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    SAMPLE  = 3'd3,
    PUBLISH = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [TW-1:0]       timer;
  logic [IW-1:0]       idx;
  logic [CW-1:0]       clr_cnt;
  logic                pend_clr;
  logic [31:0]         prev   [NCH];
  logic [31:0]         snap   [NCH];
  logic [VW-1:0]       shadow [NCH];
  logic [NCH*VW-1:0]   shadow_flat;
  logic                running;
  logic                running_nx;
  logic                timer_wrap;
  logic signed [31:0]  diff_sh;
  logic [VW-1:0]       vel_sat;

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_flat
      assign shadow_flat[VW*g +: VW] = shadow[g];
    end
  endgenerate

  assign running    = (state == RUN) || (state == SAMPLE) || (state == PUBLISH);
  assign running_nx = (state_nx == RUN) || (state_nx == SAMPLE) || (state_nx == PUBLISH);
  assign timer_wrap = (timer == TW'(PERIOD - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = CLEAR;
      CLEAR:   if (clr_cnt == CW'(CLR_CYC - 1)) state_nx = enable ? RUN : IDLE;
      RUN: begin
        if (!enable)                  state_nx = IDLE;
        else if (clr_req || pend_clr) state_nx = CLEAR;
        else if (tick)                state_nx = SAMPLE;
      end
      SAMPLE:  if (idx == IW'(NCH - 1)) state_nx = PUBLISH;
      PUBLISH: state_nx = enable ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Modulo-2^32 difference makes a counter wrap inside one period come out right.
  always_comb begin
    diff_sh = $signed(snap[idx] - prev[idx]) >>> SHIFT;
    if (diff_sh > VMAX)      vel_sat = VMAX[VW-1:0];
    else if (diff_sh < VMIN) vel_sat = VMIN[VW-1:0];
    else                     vel_sat = diff_sh[VW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      idx       <= '0;
      clr_cnt   <= '0;
      pend_clr  <= 1'b0;
      tick      <= 1'b0;
      busy      <= 1'b0;
      cnt_start <= '0;
      cnt_clr_n <= '1;
      vel_out   <= '0;
      vel_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        prev[i]   <= '0;
        snap[i]   <= '0;
        shadow[i] <= '0;
      end
    end else begin
      state     <= state_nx;
      busy      <= (state_nx != IDLE);
      cnt_start <= {NCH{running_nx}};
      cnt_clr_n <= {NCH{state_nx != CLEAR}};

      // Timer free-runs across SAMPLE/PUBLISH so ticks stay exactly PERIOD apart.
      if (running && running_nx) begin
        timer <= timer_wrap ? '0 : timer + 1'b1;
        tick  <= timer_wrap;
      end else begin
        timer <= '0;
        tick  <= 1'b0;
      end

      clr_cnt <= (state == CLEAR && state_nx == CLEAR) ? clr_cnt + 1'b1 : '0;

      if (state == CLEAR) begin
        pend_clr <= 1'b0;
        for (int i = 0; i < NCH; i++) prev[i] <= '0;
      end else if ((state == SAMPLE || state == PUBLISH) && clr_req) begin
        pend_clr <= 1'b1;
      end

      if (state == RUN && state_nx == SAMPLE) begin
        idx <= '0;
        for (int i = 0; i < NCH; i++) snap[i] <= cnt_in[32*i +: 32];
      end

      if (state == SAMPLE) begin
        shadow[idx] <= vel_sat;
        prev[idx]   <= snap[idx];
        idx         <= idx + 1'b1;
      end

      if (state == PUBLISH) begin
        vel_out   <= shadow_flat;
        vel_valid <= 1'b1;
        if (vel_valid) overrun <= !vel_ack;
      end else if (vel_valid && vel_ack) begin
        vel_valid <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_encoder_sampler.sv
`default_nettype none
// tb_encoder_sampler: directed and randomized checks of encoder_sampler
// against a cycle-level behavioural model.
module tb_encoder_sampler;

  localparam int NCH     = 4;
  localparam int PERIOD  = 16;
  localparam int SHIFT   = 7;
  localparam int VW      = 16;
  localparam int CLR_CYC = 2;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic              enable  = 1'b0;
  logic              clr_req = 1'b0;
  logic              vel_ack = 1'b0;
  logic [NCH*32-1:0] cnt_in  = '0;
  logic [NCH-1:0]    cnt_start;
  logic [NCH-1:0]    cnt_clr_n;
  logic [NCH*VW-1:0] vel_out;
  logic              vel_valid;
  logic              overrun;
  logic              tick;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  encoder_sampler #(
    .NCH(NCH), .PERIOD(PERIOD), .SHIFT(SHIFT), .VW(VW), .CLR_CYC(CLR_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr_req(clr_req),
    .cnt_in(cnt_in), .cnt_start(cnt_start), .cnt_clr_n(cnt_clr_n),
    .vel_out(vel_out), .vel_valid(vel_valid), .vel_ack(vel_ack),
    .overrun(overrun), .tick(tick), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Velocity from the rules: wrap-aware delta, floor-divide by 2^SHIFT, clamp.
  function automatic int ref_vel(input logic [31:0] cur, input logic [31:0] old);
    logic [31:0] raw;
    longint d, q, lim;
    raw = cur - old;
    d   = longint'($signed(raw));
    q   = d / (longint'(1) << SHIFT);
    if (d < 0 && (d % (longint'(1) << SHIFT)) != 0) q = q - 1;
    lim = longint'(1) << (VW - 1);
    if (q > lim - 1) q = lim - 1;
    if (q < -lim)    q = -lim;
    return int'(q);
  endfunction

  // Model: mode 0 idle, 1 clearing, 2 running; m_seq counts cycles since the tick.
  int          m_mode, m_clr, m_t, m_seq;
  logic        m_pend, m_adv, m_pub, m_tick_now;
  logic [31:0] m_prev [NCH];
  int          m_newvel [NCH];
  logic        e_tick, e_valid, e_over, e_start, e_clrn, e_busy;
  int          e_vel [NCH];
  logic        model_live = 1'b0;

  task automatic model_step();
    if (!rst_n) begin
      m_mode = 0; m_clr = 0; m_t = 0; m_seq = 0; m_pend = 1'b0;
      e_tick = 1'b0; e_valid = 1'b0; e_over = 1'b0;
      e_start = 1'b0; e_clrn = 1'b1; e_busy = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_prev[i] = '0; e_vel[i] = 0; m_newvel[i] = 0;
      end
      model_live = 1'b1;
    end else begin
      m_tick_now = e_tick;
      m_adv      = 1'b0;
      m_pub      = (m_mode == 2) && (m_seq == NCH + 1);
      if (!m_pub && e_valid && vel_ack) begin
        e_valid = 1'b0; e_over = 1'b0;
      end
      case (m_mode)
        0: if (enable) begin m_mode = 1; m_clr = 0; end
        1: begin
          for (int i = 0; i < NCH; i++) m_prev[i] = '0;
          m_pend = 1'b0;
          m_clr++;
          if (m_clr == CLR_CYC) begin
            m_mode = enable ? 2 : 0; m_seq = 0;
          end
        end
        default: begin
          if (m_seq == 0) begin
            if (!enable) m_mode = 0;
            else if (clr_req || m_pend) begin m_mode = 1; m_clr = 0; end
            else begin
              m_adv = 1'b1;
              if (m_tick_now) begin
                for (int i = 0; i < NCH; i++) begin
                  m_newvel[i] = ref_vel(cnt_in[32*i +: 32], m_prev[i]);
                  m_prev[i]   = cnt_in[32*i +: 32];
                end
                m_seq = 1;
              end
            end
          end else begin
            if (clr_req) m_pend = 1'b1;
            m_adv = 1'b1;
            if (m_seq == NCH + 1) begin
              if (e_valid) e_over = !vel_ack;
              e_valid = 1'b1;
              for (int i = 0; i < NCH; i++) e_vel[i] = m_newvel[i];
              m_seq = 0;
              if (!enable) begin m_mode = 0; m_adv = 1'b0; end
            end else begin
              m_seq++;
            end
          end
        end
      endcase
      if (m_adv) begin
        e_tick = (m_t == PERIOD - 1);
        m_t    = e_tick ? 0 : m_t + 1;
      end else begin
        e_tick = 1'b0; m_t = 0;
      end
      e_start = (m_mode == 2);
      e_clrn  = (m_mode != 1);
      e_busy  = (m_mode != 0);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_live) begin
      chk("cnt_start", cnt_start, {NCH{e_start}});
      chk("cnt_clr_n", cnt_clr_n, {NCH{e_clrn}});
      chk("tick",      tick,      e_tick);
      chk("busy",      busy,      e_busy);
      chk("vel_valid", vel_valid, e_valid);
      chk("overrun",   overrun,   e_over);
      for (int i = 0; i < NCH; i++)
        chk($sformatf("vel_out%0d", i), vel_out[VW*i +: VW], e_vel[i][VW-1:0]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    @(negedge clk);
    while (tick !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (tick !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL tick_wait: tick still %b after 40 cycles", tick);
    end
  endtask

  task automatic ack_once();
    vel_ack = 1'b1;
    cyc(1);
    vel_ack = 1'b0;
  endtask

  initial begin
    cyc(3);
    chk("rst_clr_n", cnt_clr_n, 4'hF);
    chk("rst_start", cnt_start, 4'h0);
    chk("rst_valid", vel_valid, 1'b0);
    chk("rst_busy",  busy,      1'b0);
    rst_n = 1'b1;
    cnt_in[31:0]  = 32'd12800;
    cnt_in[63:32] = 32'(-4736);
    cyc(2);

    enable = 1'b1;
    cyc(1); chk("clr_low_1", cnt_clr_n, 4'h0);
    cyc(1); chk("clr_low_2", cnt_clr_n, 4'h0);
    cyc(1); chk("clr_release", cnt_clr_n, 4'hF);
    chk("start_on", cnt_start, 4'hF);
    cyc(15); chk("pre_tick", tick, 1'b0);
    cyc(1);  chk("first_tick", tick, 1'b1);
    cyc(5);  chk("valid_pre", vel_valid, 1'b0);
    cyc(1);  chk("valid_lat", vel_valid, 1'b1);
    chk("vel_100", vel_out[15:0],  16'd100);
    chk("vel_m37", vel_out[31:16], 16'hFFDB);
    chk("vel_ch2", vel_out[47:32], 16'h0000);
    chk("vel_ch3", vel_out[63:48], 16'h0000);
    ack_once();
    chk("ack_clears", vel_valid, 1'b0);
    cnt_in[31:0]  = 32'd5132800;
    cnt_in[63:32] = 32'(-5124736);
    cnt_in[95:64] = 32'h7FFFFF80;
    cyc(9); chk("tick_spacing", tick, 1'b1);
    cyc(6);
    chk("sat_pos",  vel_out[15:0],  16'h7FFF);
    chk("sat_neg",  vel_out[31:16], 16'h8000);
    chk("sat_big",  vel_out[47:32], 16'h7FFF);
    cnt_in[95:64] = 32'h80000080;
    ack_once();
    wait_tick(); cyc(6);
    chk("wrap_2",   vel_out[47:32], 16'd2);
    chk("zero_d",   vel_out[15:0],  16'd0);

    cnt_in[127:96] = 32'd640;
    wait_tick(); cyc(5);
    chk("ovr_pre", overrun, 1'b0);
    cyc(1);
    chk("ovr_set", overrun, 1'b1);
    chk("ovr_newest", vel_out[63:48], 16'd5);
    ack_once();
    chk("ovr_ack_valid", vel_valid, 1'b0);
    chk("ovr_ack_clear", overrun, 1'b0);

    wait_tick(); cyc(6);
    chk("pa_valid", vel_valid, 1'b1);
    wait_tick(); cyc(5);
    ack_once();
    chk("pub_ack_valid", vel_valid, 1'b1);
    chk("pub_ack_ovr",   overrun,   1'b0);
    ack_once();

    clr_req = 1'b1; cyc(1); clr_req = 1'b0;
    chk("clr_run", cnt_clr_n, 4'h0);
    cyc(2);  chk("clr_run_start", cnt_start, 4'hF);
    cyc(15); chk("rephase_pre", tick, 1'b0);
    cyc(1);  chk("rephase_tick", tick, 1'b1);

    cyc(2); clr_req = 1'b1; cyc(1); clr_req = 1'b0;
    cyc(3); chk("clr_pend_run", cnt_clr_n, 4'hF);
    cyc(1); chk("clr_after_pub", cnt_clr_n, 4'h0);

    wait_tick(); cyc(2); enable = 1'b0;
    cyc(4);
    chk("dis_busy",  busy,      1'b0);
    chk("dis_start", cnt_start, 4'h0);
    chk("dis_pub",   vel_valid, 1'b1);

    enable = 1'b1;
    wait_tick(); cyc(2); rst_n = 1'b0;
    cyc(1);
    chk("mid_rst_valid", vel_valid, 1'b0);
    chk("mid_rst_busy",  busy,      1'b0);
    chk("mid_rst_clrn",  cnt_clr_n, 4'hF);
    rst_n = 1'b1;
    cyc(6); chk("mid_rst_nopub", vel_valid, 1'b0);

    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      enable  = ($urandom_range(0, 99) < 99);
      clr_req = ($urandom_range(0, 99) < 2);
      vel_ack = ($urandom_range(0, 3) == 0);
      rst_n   = ($urandom_range(0, 999) != 0);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 15) == 0)
            cnt_in[32*c +: 32] = cnt_in[32*c +: 32] + 32'($urandom());
          else
            cnt_in[32*c +: 32] = cnt_in[32*c +: 32] + 32'(int'($urandom_range(0, 60000)) - 30000);
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b0; clr_req = 1'b0; vel_ack = 1'b0;
    cyc(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/encoder_sampler.md
# encoder_sampler

Periodic sampling controller for the per-wheel quadrature counters. It sequences the counters' clear and start controls and snapshots all counts on a fixed tick. It converts each count difference into a saturated signed per-period velocity and hands the result set to the CPU bus through a valid/ack handshake with overrun detection. It sits between the NCH counter instances and the motor-control register file.

## Interface
- NCH, 4: number of encoder channels.
- PERIOD, 50000: clocks between sample ticks (1 ms at 50 MHz); legal range PERIOD ≥ NCH+4.
- SHIFT, 7: fixed left-shift applied by the counters to their outputs; removed here.
- VW, 16: signed width of each velocity result.
- CLR_CYC, 2: cycles the counter clear is held low.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  level; 1 = run sampling.
- clr_req  in  1  one-cycle pulse; request counter clear.
- cnt_in  in  NCH*32  counter outputs; channel i is at [32i+31:32i].
- cnt_start  out  NCH  count enable to each counter (all bits equal).
- cnt_clr_n  out  NCH  active-low clear to each counter (all bits equal).
- vel_out  out  NCH*VW  velocity set; channel i is at [VW*i+VW-1:VW*i].
- vel_valid  out  1  vel_out holds an unconsumed sample.
- vel_ack  in  1  consumer acknowledge; meaningful only while vel_valid=1.
- overrun  out  1  sticky; a sample was overwritten before it was acked.
- tick  out  1  one-cycle pulse per sample instant.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, CLEAR, RUN, SAMPLE, PUBLISH.
- Reset values:
  - state = IDLE.
  - cnt_start = 0 and cnt_clr_n = all 1.
  - vel_out = 0, vel_valid = 0, overrun = 0, tick = 0, busy = 0.
  - timer = 0, channel index = 0, previous counts = 0, clear-pending flag = 0.
- IDLE:
  - cnt_start = 0.
  - enable = 1 → CLEAR.
- CLEAR:
  - cnt_clr_n = 0 and cnt_start = 0 for exactly CLR_CYC cycles.
  - All previous-count registers and the timer are set to 0; the clear-pending flag is cleared.
  - Then → RUN.
- RUN:
  - cnt_start = all 1.
  - timer increments each cycle; when it reaches PERIOD-1 it wraps to 0 and tick = 1 that cycle.
  - At the end of the tick cycle, all NCH cnt_in words are captured together into snapshot registers, and the state → SAMPLE with index 0.
- SAMPLE, one channel per cycle, index 0..NCH-1:
  - d = snap[i] − prev[i], modulo 2^32.
  - v = d >>> SHIFT (arithmetic shift).
  - Saturate v to the signed VW range [−2^(VW−1), 2^(VW−1)−1] and store it in the shadow register.
  - prev[i] ← snap[i].
  - After index NCH-1 → PUBLISH.
- PUBLISH (one cycle):
  - vel_out ← shadow and vel_valid ← 1.
  - If vel_valid was already 1 and vel_ack is 0 this cycle, overrun ← 1.
  - Then → RUN.
- The timer and cnt_start keep running through SAMPLE and PUBLISH, so the tick spacing is exactly PERIOD cycles.
- Handshake:
  - vel_ack=1 while vel_valid=1, outside PUBLISH → next cycle vel_valid=0 and overrun=0.
  - vel_ack=1 in the PUBLISH cycle acknowledges the old sample: the new sample is loaded, vel_valid stays 1, and overrun is not set.
  - vel_ack while vel_valid=0 is ignored.
- clr_req:
  - In RUN → CLEAR on the next cycle; the timer restarts from 0 after CLEAR.
  - In SAMPLE or PUBLISH it sets the pending flag; the clear is taken on the first RUN cycle.
  - In IDLE or CLEAR it is ignored.
  - vel_valid, vel_out and overrun are not affected by a clear.
- enable = 0:
  - In RUN → IDLE next cycle.
  - In SAMPLE or PUBLISH, the sequence completes through PUBLISH and then → IDLE.
  - In CLEAR, the clear completes and then → IDLE.
  - Re-enabling always passes through CLEAR.
- Counter wrap: because subtraction is modulo 2^32, a counter wrap within one period yields the true edge delta.
- rst_n = 0 in any state forces reset values on the next edge; a pending publish is discarded.

## Timing
- tick is high in cycle T and the snapshot is taken at the edge ending T.
- SAMPLE occupies cycles T+1..T+NCH and PUBLISH cycle T+NCH+1; vel_valid and the new vel_out appear from cycle T+NCH+2.
- After enable rises in cycle E:
  - CLEAR occupies E+1..E+CLR_CYC, then RUN starts.
  - The first tick occurs PERIOD cycles after the first RUN cycle.
- All outputs are registered; there are no combinational paths from input to output.
- The counters act on cnt_start and cnt_clr_n one clk after they change.

## Test plan
- Reset, enable: with PERIOD=16, raise enable.
  - Expect cnt_clr_n low for exactly 2 cycles, then cnt_start=1.
  - Expect a tick every 16 cycles and vel_valid exactly 6 cycles after each tick.
- Velocity values: drive ch0 cnt_in from 0 to 100<<7 and ch1 to (−37)<<7 within one period → vel_out ch0 = 100, ch1 = −37, ch2 = ch3 = 0.
- Saturation and wrap:
  - A delta of 40000<<7 gives 32767; a delta of −40000<<7 gives −32768.
  - prev = 0x7FFFFF80 → cur = 0x80000080 gives +2.
- Handshake and overrun:
  - Leave the sample un-acked across two ticks → overrun = 1 and vel_out holds the newest sample.
  - Ack → vel_valid = 0 and overrun = 0.
  - Ack exactly in the PUBLISH cycle → vel_valid stays 1 and overrun stays 0.
- clr_req timing:
  - clr_req in RUN → CLEAR next cycle and the tick phase restarts.
  - clr_req during SAMPLE → CLEAR begins right after PUBLISH, and the published values are unaffected.
- Disable and reset mid-sequence:
  - Drop enable during SAMPLE → PUBLISH completes, then IDLE with cnt_start = 0.
  - Assert rst_n = 0 during SAMPLE → all outputs at reset values and no publish occurs.
